// File: rtl/bus_arb_pkg.sv
// Shared types and width helpers for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_HANDOFF = 2'd2
  } arb_state_e;

  function automatic int bus_dataw(input int addrw);
    return addrw + 8;
  endfunction

  function automatic int bus_idw(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

  function automatic bit max_hold_ok(input int max_hold);
    return max_hold >= 2;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index after i_last, wrapping.
module rr_pick #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   i_elig,
  input  logic [IDW-1:0] i_last,
  output logic [IDW-1:0] o_winner,
  output logic           o_any
);

  int w_best;
  int w_dist;

  // Distance of index j from the slot just after i_last; smallest eligible wins.
  always_comb begin
    o_winner = '0;
    w_best   = N;
    w_dist   = 0;
    for (int j = 0; j < N; j++) begin
      w_dist = (j + 2 * N - int'(i_last) - 1) % N;
      if (i_elig[j] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_winner = IDW'(j);
      end
    end
  end

  assign o_any = |i_elig;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared accelerator bus with turnaround bubble and hold watchdog.
// Handshake: a requester holds arb_req high until it sees its arb_grant bit, keeps it high for its tenure, and drops it to release.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int  NUM_REQ  = 2,
  parameter int  ADDRW    = 24,
  parameter int  MAX_HOLD = 64,
  localparam int DATAW    = bus_dataw(ADDRW),
  localparam int IDW      = bus_idw(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       arb_req,
  output logic [NUM_REQ-1:0]       arb_grant,
  input  logic [NUM_REQ*DATAW-1:0] req_bus,
  output logic [DATAW-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [IDW-1:0]           owner_id,
  output logic                     timeout_pulse,
  output logic [IDW-1:0]           timeout_id,
  output logic [1:0]               dbg_state
);

  localparam int CNTW = $clog2(MAX_HOLD);

  if (!max_hold_ok(MAX_HOLD)) begin : g_bad_max_hold
    $error("bus_arbiter: MAX_HOLD must be >= 2");
  end

  arb_state_e         r_state, w_state_nxt;
  logic [IDW-1:0]     r_owner, w_owner_nxt;
  logic [IDW-1:0]     r_last, w_last_nxt;
  logic [CNTW-1:0]    r_hold_cnt, w_hold_nxt;
  logic [NUM_REQ-1:0] r_mask, w_mask_set;
  logic               r_timeout_pulse;
  logic [IDW-1:0]     r_timeout_id;

  logic [NUM_REQ-1:0] w_elig;
  logic [IDW-1:0]     w_winner;
  logic               w_any;
  logic               w_owner_req;
  logic               w_timeout;

  assign w_elig = arb_req & ~r_mask;

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_rr_pick (
    .i_elig   (w_elig),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  always_comb begin
    w_owner_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == IDW'(i)) w_owner_req = arb_req[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_owner         <= '0;
      r_last          <= IDW'(NUM_REQ - 1);
      r_hold_cnt      <= '0;
      r_mask          <= '0;
      r_timeout_pulse <= 1'b0;
      r_timeout_id    <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_owner         <= w_owner_nxt;
      r_last          <= w_last_nxt;
      r_hold_cnt      <= w_hold_nxt;
      r_mask          <= (r_mask & arb_req) | w_mask_set;
      r_timeout_pulse <= w_timeout;
      if (w_timeout) r_timeout_id <= r_owner;
    end
  end

  // HANDOFF arbitrates exactly like IDLE, which gives the one-cycle bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold_cnt;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE, ST_HANDOFF: begin
        if (w_any) begin
          w_state_nxt = ST_GRANT;
          w_owner_nxt = w_winner;
          w_last_nxt  = w_winner;
          w_hold_nxt  = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        w_hold_nxt = r_hold_cnt + CNTW'(1);
        if (!w_owner_req) begin
          w_state_nxt = ST_HANDOFF;
        end else if (r_hold_cnt == CNTW'(MAX_HOLD - 1)) begin
          w_state_nxt = ST_HANDOFF;
          w_timeout   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_mask_set = '0;
    arb_grant  = '0;
    bus_out    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == IDW'(i)) begin
        w_mask_set[i] = w_timeout;
        if (r_state == ST_GRANT) begin
          arb_grant[i] = 1'b1;
          bus_out      = req_bus[i*DATAW +: DATAW];
        end
      end
    end
  end

  assign bus_valid     = (r_state == ST_GRANT);
  assign owner_id      = (r_state == ST_GRANT) ? r_owner : '0;
  assign timeout_pulse = r_timeout_pulse;
  assign timeout_id    = r_timeout_id;
  assign dbg_state     = r_state;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single accelerator/memory data bus between accelerator control FSMs, for example the AES and SHA request sequencers.
- Each FSM raises its `arb_req` and waits for its `arb_grant` bit.
- The winner's bus word (`ADDRW+8` bits) is muxed onto the shared bus for the duration of its tenure.
- Grants are round-robin fair, with a one-cycle turnaround bubble and a watchdog that reclaims the bus from a hung requester.

Parameters:
- NUM_REQ, 2, number of requesting FSMs (2..8).
- ADDRW, 24, address width; bus word width `DATAW = ADDRW+8`.
- MAX_HOLD, 64, maximum consecutive GRANT cycles before forced release (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- arb_req  in  NUM_REQ  per-requester bus request; bit i = FSM i
- arb_grant  out  NUM_REQ  one-hot (or zero) grant
- req_bus  in  NUM_REQ*DATAW  concatenated requester bus words; slice i = `[i*DATAW +: DATAW]`
- bus_out  out  DATAW  shared bus word
- bus_valid  out  1  high while a requester owns the bus
- owner_id  out  $clog2(NUM_REQ) (min 1)  index of current owner; 0 when idle
- timeout_pulse  out  1  one-cycle pulse on forced release
- timeout_id  out  $clog2(NUM_REQ) (min 1)  requester reclaimed by the last timeout; holds value until next timeout

Behaviour:
- Reset (async, `rst_n` low) forces immediately, mid-tenure included:
  - state=IDLE, arb_grant=0, bus_valid=0, owner_id=0;
  - timeout_pulse=0, timeout_id=0;
  - hold_cnt=0, mask=0;
  - last=NUM_REQ-1, so requester 0 wins first.
- States: IDLE, GRANT, HANDOFF (encoding in package).
- Eligible set = `arb_req & ~mask`.
- Round-robin pick: first eligible index scanning `last+1, last+2, ...` modulo NUM_REQ (wrap-around).
- IDLE:
  - If eligible set is non-zero at edge k: state=GRANT; arb_grant/owner_id set to winner after edge k; last<=winner; hold_cnt<=0.
  - Grant latency: 1 cycle from sampled request.
  - A request raised and dropped between edges is never granted.
- GRANT:
  - `bus_out = req_bus[owner]` combinationally; `bus_valid=1`.
  - Non-owners' arb_req changes have no effect.
  - hold_cnt increments each cycle.
  - Normal release: `arb_req[owner]==0` at an edge -> arb_grant=0, bus_valid=0, state=HANDOFF.
  - Forced release: `arb_req[owner]==1` and `hold_cnt==MAX_HOLD-1` -> same transition as normal release, plus:
    - timeout_pulse=1 for exactly one cycle;
    - timeout_id=owner;
    - mask[owner]<=1.
  - Tenure is capped at MAX_HOLD cycles.
- HANDOFF:
  - Exactly one cycle; bus_out=0, bus_valid=0.
  - Then arbitrates like IDLE: grant at next edge if eligible, else IDLE.
  - Minimum bus gap between tenures is 1 cycle. Back-to-back different owners: release edge k, new grant visible after edge k+1.
- Mask:
  - mask[i] clears on any edge where `arb_req[i]==0`.
  - A reclaimed requester must drop its request for at least one cycle before it is eligible again.
  - If all requesters are masked, the arbiter stays IDLE.
- bus_out=0 whenever bus_valid=0 (no stale data on the bus).
- Simultaneous requests: the rotating pointer alone decides. Two continuously requesting FSMs alternate strictly, 0,1,0,1...
- Owner drops its request on the same edge that hold_cnt hits MAX_HOLD-1: treated as normal release, no timeout.
- NUM_REQ=1: degenerates to grant/HANDOFF/grant; pointer is unused.

Decomposition:
- Package `bus_arb_pkg` holds:
  - state typedef/encoding (IDLE=2'd0, GRANT=2'd1, HANDOFF=2'd2);
  - `DATAW` and `IDW` width functions;
  - `MAX_HOLD` bound check.
- One sub-module: `rr_pick`, purely combinational. Inputs: eligible vector and last index. Outputs: winner index and any-valid. Kept separate so it can be unit-checked exhaustively.
- Counters, mask and the bus mux live in `bus_arbiter`.

Test Plan:
- Reset, then `arb_req=2'b01` at edge 3 -> arb_grant=2'b01 after edge 3; bus_out equals slice 0 (e.g. 32'hA5_000100); bus_valid=1.
- `arb_req=2'b11` held constant, each owner drops its request after 4 cycles then re-raises -> grant sequence 01, 10, 01, 10. Exactly one bubble cycle with bus_valid=0 and bus_out=0 between tenures.
- MAX_HOLD=16, requester 1 holds its request forever -> grant drops after 16 grant cycles; timeout_pulse high 1 cycle; timeout_id=1. Requester 1 gets no regrant until it drops its request for >=1 cycle; requester 0 (requesting) is granted after the bubble.
- Owner 0 drops its request exactly on the hold_cnt=15 edge -> no timeout_pulse; mask stays 0.
- rst_n pulled low mid-GRANT (asynchronously, between edges) -> arb_grant=0, bus_valid=0, bus_out=0 immediately. After release with both requesting, requester 0 wins first.
- 1-cycle glitch on `arb_req[1]` between edges while IDLE -> no grant.
